// File: rtl/hex_entry_ctrl_pkg.sv
// Shared types and constants for the hex entry sequencer: state encoding,
// buffer geometry and the ranking of simultaneous pulse events.
package hex_entry_ctrl_pkg;

  localparam int NIBBLES = 4;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    VIEW  = 2'd0,
    EDIT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Larger encoding wins when several pulses land in the same cycle.
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_DIGIT = 3'd1,
    EV_PRE   = 3'd2,
    EV_NXT   = 3'd3,
    EV_BS    = 3'd4,
    EV_EXE   = 3'd5
  } event_t;

  function automatic event_t decode_event(input logic exe, input logic bs,
                                          input logic nxt, input logic pre,
                                          input logic digit);
    if (exe)        return EV_EXE;
    else if (bs)    return EV_BS;
    else if (nxt)   return EV_NXT;
    else if (pre)   return EV_PRE;
    else if (digit) return EV_DIGIT;
    else            return EV_NONE;
  endfunction

endpackage

// File: rtl/hex_entry_ctrl_prio_enc16.sv
// 16-bit lowest-index-wins priority encoder, used to decode the hex key pulses.
module prio_enc16 (
  input  logic [15:0] req,
  output logic        valid,
  output logic [3:0]  idx
);

  always_comb begin
    valid = |req;
    idx   = 4'd0;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) idx = i[3:0];
    end
  end

endmodule

// File: rtl/hex_entry_ctrl.sv
// Turns key/navigation pulses into cursor moves, nibble entry and one-cycle
// register-file write strobes; selects the displayed word.
module hex_entry_ctrl
  import hex_entry_ctrl_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       d_ps,
  input  logic              bs_ps,
  input  logic              pre_ps,
  input  logic              nxt_ps,
  input  logic              exe_ps,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] rf_raddr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] disp,
  output logic              editing,
  output logic [2:0]        digit_cnt,
  output logic              ovf,
  output logic              done
);

  localparam logic [2:0]        CNT_FULL = 3'(NIBBLES);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cursor;
  logic [DATA_W-1:0]   entry_buf;
  logic [2:0]          cnt;
  logic                ovf_q;

  logic                dig_vld;
  logic [3:0]          nib;
  event_t              ev;
  logic [ADDR_W-1:0]   cursor_inc;
  logic [ADDR_W-1:0]   cursor_dec;

  prio_enc16 u_dig_enc (
    .req   (d_ps),
    .valid (dig_vld),
    .idx   (nib)
  );

  assign ev         = decode_event(exe_ps, bs_ps, nxt_ps, pre_ps, dig_vld);
  assign cursor_inc = (cursor == LAST) ? '0 : cursor + ADDR_W'(1);
  assign cursor_dec = (cursor == '0) ? LAST : cursor - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= VIEW;
      cursor    <= '0;
      entry_buf <= '0;
      cnt       <= 3'd0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state)
        VIEW: begin
          case (ev)
            EV_DIGIT: begin
              entry_buf <= {12'h000, nib};
              cnt       <= 3'd1;
              state     <= EDIT;
            end
            EV_NXT:  cursor <= cursor_inc;
            EV_PRE:  cursor <= cursor_dec;
            default: ;
          endcase
        end
        EDIT: begin
          case (ev)
            EV_EXE: state <= WRITE;
            EV_BS: begin
              if (cnt == 3'd1) begin
                entry_buf <= '0;
                cnt       <= 3'd0;
                state     <= VIEW;
              end else begin
                entry_buf <= entry_buf >> 4;
                cnt       <= cnt - 3'd1;
              end
            end
            EV_NXT, EV_PRE: begin
              entry_buf <= '0;
              cnt       <= 3'd0;
              cursor    <= (ev == EV_NXT) ? cursor_inc : cursor_dec;
              state     <= VIEW;
            end
            EV_DIGIT: begin
              if (cnt != CNT_FULL) begin
                entry_buf <= {entry_buf[11:0], nib};
                cnt       <= cnt + 3'd1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        WRITE: begin
          // Commit cycle: inputs ignored, advance to the next address.
          cursor    <= cursor_inc;
          entry_buf <= '0;
          cnt       <= 3'd0;
          state     <= VIEW;
        end
        default: state <= VIEW;
      endcase
    end
  end

  assign rf_raddr  = cursor;
  assign rf_we     = (state == WRITE);
  assign done      = (state == WRITE);
  assign rf_waddr  = cursor;
  assign rf_wdata  = entry_buf;
  assign editing   = (state == EDIT);
  assign digit_cnt = cnt;
  assign ovf       = ovf_q;
  assign disp      = (state == VIEW) ? rf_rdata : entry_buf;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Directed bench for hex_entry_ctrl with a register-file model and a
// write-strobe scoreboard.
module tb_hex_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_ps;
  logic        bs_ps, pre_ps, nxt_ps, exe_ps;
  logic [15:0] rf_rdata;
  logic [2:0]  rf_raddr;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] disp;
  logic        editing;
  logic [2:0]  digit_cnt;
  logic        ovf;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] exp_q[$];
  logic [18:0] exp_w;

  logic [15:0] rf [8] = '{16'hA000, 16'hB111, 16'hC222, 16'hD333,
                          16'hE444, 16'hF555, 16'h0666, 16'h1777};

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (rf_we === 1'b1) rf[rf_waddr] <= rf_wdata;
  end

  hex_entry_ctrl #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .d_ps      (d_ps),
    .bs_ps     (bs_ps),
    .pre_ps    (pre_ps),
    .nxt_ps    (nxt_ps),
    .exe_ps    (exe_ps),
    .rf_rdata  (rf_rdata),
    .rf_raddr  (rf_raddr),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .disp      (disp),
    .editing   (editing),
    .digit_cnt (digit_cnt),
    .ovf       (ovf),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [15:0] d, input logic b, input logic p,
                      input logic n, input logic e);
    d_ps = d; bs_ps = b; pre_ps = p; nxt_ps = n; exe_ps = e;
    @(posedge clk);
    #1;
    d_ps = '0; bs_ps = 0; pre_ps = 0; nxt_ps = 0; exe_ps = 0;
  endtask

  task automatic digit(input int v);
    logic [15:0] onehot;
    onehot = 16'h0001 << v;
    step(onehot, 0, 0, 0, 0);
  endtask

  // Every write strobe must match the oldest expected commit.
  always @(negedge clk) begin
    if (rf_we === 1'b1 || done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {12'h0, done, rf_we, rf_waddr, rf_wdata}, 32'h0);
      end else begin
        exp_w = exp_q.pop_front();
        chk("write_strobe", {12'h0, done, rf_we, rf_waddr, rf_wdata},
            {12'h0, 1'b1, 1'b1, exp_w});
      end
    end
  end

  initial begin
    rst = 1'b1; d_ps = '0; bs_ps = 0; pre_ps = 0; nxt_ps = 0; exe_ps = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_raddr", rf_raddr, 3'd0);
    chk("rst_editing", editing, 1'b0);
    chk("rst_cnt", digit_cnt, 3'd0);
    chk("rst_flags", {rf_we, ovf, done}, 3'b000);
    chk("rst_disp", disp, 16'hA000);
    rst = 1'b0;

    // Cursor navigation with wrap
    step('0, 0, 0, 1, 0); chk("nav1", rf_raddr, 3'd1);
    step('0, 0, 0, 1, 0); chk("nav2", rf_raddr, 3'd2);
    step('0, 0, 0, 1, 0); chk("nav3", rf_raddr, 3'd3);
    step('0, 0, 1, 0, 0); chk("nav4", rf_raddr, 3'd2);
    step('0, 0, 1, 0, 0); chk("nav5", rf_raddr, 3'd1);
    step('0, 0, 1, 0, 0); chk("nav6", rf_raddr, 3'd0);
    step('0, 0, 1, 0, 0); chk("nav7_wrap", rf_raddr, 3'd7);
    chk("nav7_disp", disp, 16'h1777);
    step('0, 0, 0, 1, 0); chk("nav_wrap_up", rf_raddr, 3'd0);

    // Enter 1A3F and commit to address 0
    digit(1);  chk("e1_disp", disp, 16'h0001); chk("e1_edit", editing, 1'b1);
    digit(10); chk("e2_disp", disp, 16'h001A);
    digit(3);  chk("e3_disp", disp, 16'h01A3);
    digit(15); chk("e4_disp", disp, 16'h1A3F); chk("e4_cnt", digit_cnt, 3'd4);
    exp_q.push_back({3'd0, 16'h1A3F});
    step('0, 0, 0, 0, 1);
    chk("wr_we", {rf_we, done}, 2'b11);
    chk("wr_editing", editing, 1'b0);
    step('0, 0, 0, 0, 0);
    chk("wr_after_we", rf_we, 1'b0);
    chk("wr_after_cursor", rf_raddr, 3'd1);
    chk("wr_after_cnt", digit_cnt, 3'd0);
    step('0, 0, 1, 0, 0);
    chk("wr_landed", disp, 16'h1A3F);
    step('0, 0, 0, 1, 0);

    // Overflow then backspace
    digit(1); digit(2); digit(3); digit(4);
    chk("ov_4_disp", disp, 16'h1234); chk("ov_4_ovf", ovf, 1'b0);
    digit(5);
    chk("ov_5_disp", disp, 16'h1234); chk("ov_5_cnt", digit_cnt, 3'd4);
    chk("ov_5_ovf", ovf, 1'b1);
    step('0, 1, 0, 0, 0);
    chk("bs1_disp", disp, 16'h0123); chk("bs1_ovf", ovf, 1'b0);
    step('0, 1, 0, 0, 0);
    chk("bs2_disp", disp, 16'h0012); chk("bs2_cnt", digit_cnt, 3'd2);
    step('0, 0, 0, 1, 0);
    chk("discard_state", {editing, digit_cnt}, 4'b0000);
    chk("discard_cursor", rf_raddr, 3'd2);
    chk("discard_disp", disp, 16'hC222);

    // Single digit erased, exe in VIEW does nothing
    digit(7); chk("s_disp", disp, 16'h0007);
    step('0, 1, 0, 0, 0);
    chk("s_bs_state", {editing, digit_cnt}, 4'b0000);
    chk("s_bs_disp", disp, 16'hC222);
    step('0, 0, 0, 0, 1);
    chk("s_exe_we", rf_we, 1'b0);
    step('0, 0, 0, 0, 0);
    chk("s_exe_cursor", rf_raddr, 3'd2);

    // Priority: nxt beats digit; lowest digit index wins
    step(16'h0024, 0, 0, 1, 0);
    chk("p_cursor", rf_raddr, 3'd3); chk("p_edit", editing, 1'b0);
    step(16'h0024, 0, 0, 0, 0);
    chk("p_dig_edit", editing, 1'b1); chk("p_dig_disp", disp, 16'h0002);
    step(16'h0000, 1, 0, 0, 1);
    chk("p_exe_over_bs", rf_we, 1'b1);
    exp_q.push_back({3'd3, 16'h0002});
    step('0, 0, 0, 0, 0);
    chk("p_after_cursor", rf_raddr, 3'd4);

    // Reset during the WRITE cycle
    digit(9); chk("r_disp", disp, 16'h0009);
    exp_q.push_back({3'd4, 16'h0009});
    step('0, 0, 0, 0, 1);
    chk("r_we", rf_we, 1'b1);
    rst = 1'b1;
    step('0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("r_cursor", rf_raddr, 3'd0);
    chk("r_state", {editing, digit_cnt, rf_we, done}, 6'b0);
    chk("r_disp_view", disp, 16'h1A3F);
    repeat (4) step('0, 0, 0, 0, 0);
    chk("r_no_write", rf_we, 1'b0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
